tnoc_vc_scheduler: RTL and testbench
====================================

TNOC_VC_SCHEDULER -- requirements
Module: tnoc_vc_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of virtual channels; legal range 1..8.
REQ-002 SHALL have parameter CREDITS, default 8: downstream per-VC buffer depth in flits; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid, input, CHANNELS bits: head-of-FIFO valid per VC.
REQ-006 SHALL have port i_tail, input, CHANNELS bits: tail flag of the head flit per VC.
REQ-007 SHALL have port o_ready, output, CHANNELS bits: pop strobe back to each VC FIFO.
REQ-008 SHALL have port o_grant, output, CHANNELS bits: one-hot or zero flit-mux select.
REQ-009 SHALL have port o_valid, output, 1 bit: a flit is presented downstream this cycle.
REQ-010 SHALL have port i_credit_return, input, CHANNELS bits: one-cycle credit pulse per VC from downstream.
REQ-011 SHALL have port o_credit_error, output, 1 bit: sticky credit-overflow flag.

Function
REQ-012 SHALL keep per-VC credit counters, width $clog2(CREDITS+1), each reset to CREDITS.
REQ-013 SHALL treat VC i as eligible when i_valid[i]=1 and credit[i]!=0.
REQ-014 SHALL implement a two-state FSM with states IDLE and LOCKED; reset state is IDLE.
REQ-015 In IDLE, o_grant, o_ready and o_valid SHALL all be 0.
REQ-016 In IDLE, when any VC is eligible, SHALL pick the first eligible VC in round-robin order, starting at the index after the round-robin pointer; the search wraps from CHANNELS-1 to 0.
REQ-017 On that pick, SHALL register o_grant to the winner, set the round-robin pointer to the winner and enter LOCKED on the next cycle; grant latency is 1 cycle.
REQ-018 In IDLE with no eligible VC, SHALL hold all state unchanged.
REQ-019 In LOCKED with grant g, SHALL drive o_valid = i_valid[g] & (credit[g]!=0).
REQ-020 In LOCKED with grant g, SHALL drive o_ready[g] = (credit[g]!=0); all other o_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when o_valid=1.
REQ-022 On a transfer, credit[g] SHALL decrement by 1.
REQ-023 On a transfer with i_tail[g]=1, SHALL enter IDLE and clear o_grant on the next cycle; a single-flit packet (head and tail together) is legal.
REQ-024 In LOCKED, SHALL hold o_grant unchanged until the tail transfers, even when credit[g] reaches 0 (packet lock, no interleaving).
REQ-025 Each i_credit_return[i] pulse SHALL increment credit[i], in any state.
REQ-026 A simultaneous transfer and return on the same VC SHALL leave credit[i] unchanged.
REQ-027 A return with credit[i]=CREDITS and no simultaneous transfer SHALL saturate credit[i] at CREDITS and set o_credit_error on the next cycle.
REQ-028 o_credit_error SHALL remain set until reset.
REQ-029 The round-robin pointer SHALL reset to CHANNELS-1, so VC0 wins first.

Reset
REQ-030 Asserting rst_n low SHALL, immediately and including mid-packet, force: state=IDLE, o_grant=0, o_ready=0, o_valid=0, all credits=CREDITS, pointer=CHANNELS-1, o_credit_error=0.
REQ-031 After rst_n deasserts, the first arbitration SHALL occur on the first clk edge with an eligible VC.

Structure
REQ-032 The FSM state enum (IDLE, LOCKED) SHALL be declared in the shared tnoc package.
REQ-033 The credit-width derivation SHALL live in the shared tnoc package as a function of the depth.
REQ-034 A per-VC credit counter sub-module, tnoc_credit_counter (inc, dec, count, overflow), SHALL be instantiated CHANNELS times.
REQ-035 The arbitration and FSM logic SHALL stay in tnoc_vc_scheduler.

Verification
REQ-036 Reset-value check: hold rst_n=0 -> o_grant=0, o_ready=0, o_valid=0, o_credit_error=0; release with i_valid=2'b11 -> o_grant=2'b01 one cycle later.
REQ-037 Fairness: both VCs hold back-to-back 3-flit packets -> grant order VC0, VC1, VC0, VC1; one IDLE cycle between packets.
REQ-038 Packet lock under credit starvation: CREDITS=2, 4-flit packet on VC0, with VC1 eligible -> o_valid drops after 2 flits and o_grant stays 2'b01; each credit return resumes one flit; VC1 is granted only after the tail.
REQ-039 Same-cycle credit traffic: transfer and i_credit_return on the same VC in one cycle -> credit unchanged (e.g. stays 5).
REQ-040 Credit overflow: i_credit_return with credit=CREDITS -> credit stays 8; o_credit_error=1 next cycle and remains set.
REQ-041 Reset mid-packet: assert rst_n during flit 2 of 4 -> outputs 0 immediately and credits=8; after release, arbitration restarts from VC0.

Source files
------------

// File: rtl/tnoc_vc_scheduler_pkg.sv
// Shared types and helpers for the tnoc virtual-channel scheduler.
// Holds the FSM state encoding and the credit-counter width rule.
package tnoc_vc_scheduler_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  // A counter must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tnoc_vc_scheduler_if.sv
// VC-side handshake bundle between the VC FIFOs, downstream credit path and scheduler.
interface tnoc_vc_scheduler_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] i_valid;
  logic [CHANNELS-1:0] i_tail;
  logic [CHANNELS-1:0] o_ready;
  logic [CHANNELS-1:0] o_grant;
  logic                o_valid;
  logic [CHANNELS-1:0] i_credit_return;
  logic                o_credit_error;

  modport master (
    output i_valid, i_tail, i_credit_return,
    input  o_ready, o_grant, o_valid, o_credit_error
  );

  modport slave (
    input  i_valid, i_tail, i_credit_return,
    output o_ready, o_grant, o_valid, o_credit_error
  );
endinterface

// File: rtl/tnoc_credit_counter.sv
// Per-VC downstream credit counter, saturating at the buffer depth.
// overflow pulses when a return arrives with the counter already full.
module tnoc_credit_counter
  import tnoc_vc_scheduler_pkg::*;
#(
  parameter  int CREDITS = 8,
  localparam int CW      = credit_width(CREDITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (inc && !dec) begin
      if (count_q == FULL) overflow = 1'b1;
      else                 count_d  = count_q + CW'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= FULL;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tnoc_vc_scheduler.sv
// Credit-aware round-robin VC scheduler with packet lock: once a VC wins,
// it keeps the output until its tail flit transfers.
module tnoc_vc_scheduler
  import tnoc_vc_scheduler_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CREDITS  = 8
) (
  input logic                clk,
  input logic                rst_n,
  tnoc_vc_scheduler_if.slave vc
);

  localparam int CW = credit_width(CREDITS);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  sched_state_e        state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                err_q, err_d;

  logic [CW-1:0]       credit [CHANNELS];
  logic [CHANNELS-1:0] has_credit;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] dec;
  logic [CHANNELS-1:0] ovf;
  logic                locked;
  logic                xfer;
  logic                tail_hit;
  logic                found;
  int                  j;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cc
    tnoc_credit_counter #(.CREDITS(CREDITS)) u_cc (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (vc.i_credit_return[i]),
      .dec      (dec[i]),
      .count    (credit[i]),
      .overflow (ovf[i])
    );
    assign has_credit[i] = (credit[i] != '0);
  end

  assign eligible = vc.i_valid & has_credit;
  assign locked   = (state_q == LOCKED);
  assign xfer     = locked & (|(grant_q & vc.i_valid & has_credit));
  assign tail_hit = |(grant_q & vc.i_tail);
  assign dec      = xfer ? grant_q : '0;

  assign vc.o_grant        = grant_q;
  assign vc.o_ready        = locked ? (grant_q & has_credit) : '0;
  assign vc.o_valid        = xfer;
  assign vc.o_credit_error = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    err_d   = err_q | (|ovf);
    found   = 1'b0;
    j       = 0;
    unique case (state_q)
      IDLE: begin
        // Search starts one past the last winner and wraps.
        for (int k = 1; k <= CHANNELS; k++) begin
          j = int'(ptr_q) + k;
          if (j >= CHANNELS) j = j - CHANNELS;
          for (int i = 0; i < CHANNELS; i++) begin
            if (!found && (i == j) && eligible[i]) begin
              found      = 1'b1;
              grant_d    = '0;
              grant_d[i] = 1'b1;
              ptr_d      = PW'(i);
              state_d    = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        // Grant is held through credit starvation until the tail leaves.
        if (xfer && tail_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(CHANNELS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tnoc_vc_scheduler.sv
// Bench for tnoc_vc_scheduler: two instances (8 and 2 credits) checked every
// cycle against a packet-level reference model, plus directed scenarios.
module tb_tnoc_vc_scheduler;

  localparam int N = 2;
  int MAXC [2] = '{8, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] v_in [2];
  logic [1:0] t_in [2];
  logic [1:0] r_in [2];

  tnoc_vc_scheduler_if #(.CHANNELS(N)) if8 ();
  tnoc_vc_scheduler_if #(.CHANNELS(N)) if2 ();

  assign if8.i_valid         = v_in[0];
  assign if8.i_tail          = t_in[0];
  assign if8.i_credit_return = r_in[0];
  assign if2.i_valid         = v_in[1];
  assign if2.i_tail          = t_in[1];
  assign if2.i_credit_return = r_in[1];

  tnoc_vc_scheduler #(.CHANNELS(N), .CREDITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .vc(if8));
  tnoc_vc_scheduler #(.CHANNELS(N), .CREDITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .vc(if2));

  logic [1:0] o_g [2];
  logic [1:0] o_r [2];
  logic       o_v [2];
  logic       o_e [2];
  logic [7:0] cr_w [2][2];

  assign o_g[0] = if8.o_grant;  assign o_g[1] = if2.o_grant;
  assign o_r[0] = if8.o_ready;  assign o_r[1] = if2.o_ready;
  assign o_v[0] = if8.o_valid;  assign o_v[1] = if2.o_valid;
  assign o_e[0] = if8.o_credit_error; assign o_e[1] = if2.o_credit_error;
  assign cr_w[0][0] = 8'(dut8.credit[0]);
  assign cr_w[0][1] = 8'(dut8.credit[1]);
  assign cr_w[1][0] = 8'(dut2.credit[0]);
  assign cr_w[1][1] = 8'(dut2.credit[1]);

  // Reference model: packet owner, last winner, credits as plain integers.
  int m_lock [2];
  int m_g    [2];
  int m_ptr  [2];
  int m_err  [2];
  int m_cr   [2][2];
  int sent   [2][2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lock[d] = 0;
      m_g[d]    = 0;
      m_ptr[d]  = N - 1;
      m_err[d]  = 0;
      for (int i = 0; i < N; i++) begin
        m_cr[d][i] = MAXC[d];
        sent[d][i] = 0;
      end
    end
  endtask

  function automatic int exp_xfer(input int d);
    int vv;
    vv = int'(v_in[d]);
    if (m_lock[d] == 0) return 0;
    return (((vv >> m_g[d]) & 1) == 1 && m_cr[d][m_g[d]] != 0) ? 1 : 0;
  endfunction

  task automatic model_check(input int d);
    int eg, er;
    eg = m_lock[d] ? (1 << m_g[d]) : 0;
    er = (m_lock[d] != 0 && m_cr[d][m_g[d]] != 0) ? eg : 0;
    chk($sformatf("d%0d_grant", d), int'(o_g[d]), eg);
    chk($sformatf("d%0d_ready", d), int'(o_r[d]), er);
    chk($sformatf("d%0d_valid", d), int'(o_v[d]), exp_xfer(d));
    chk($sformatf("d%0d_err", d), int'(o_e[d]), m_err[d]);
    chk($sformatf("d%0d_cr0", d), int'(cr_w[d][0]), m_cr[d][0]);
    chk($sformatf("d%0d_cr1", d), int'(cr_w[d][1]), m_cr[d][1]);
  endtask

  task automatic model_update(input int d);
    int vv, tt, rr, g, ev, net;
    int old [2];
    vv = int'(v_in[d]);
    tt = int'(t_in[d]);
    rr = int'(r_in[d]);
    g  = m_g[d];
    ev = exp_xfer(d);
    for (int i = 0; i < N; i++) old[i] = m_cr[d][i];
    for (int i = 0; i < N; i++) begin
      net = ((rr >> i) & 1) - ((ev != 0 && i == g) ? 1 : 0);
      if (net > 0) begin
        if (m_cr[d][i] == MAXC[d]) m_err[d] = 1;
        else m_cr[d][i] = m_cr[d][i] + 1;
      end else if (net < 0) begin
        m_cr[d][i] = m_cr[d][i] - 1;
      end
    end
    if (ev != 0) sent[d][g] = sent[d][g] + 1;
    if (m_lock[d] != 0) begin
      if (ev != 0 && ((tt >> g) & 1) == 1) m_lock[d] = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int jj;
        jj = (m_ptr[d] + k) % N;
        if (((vv >> jj) & 1) == 1 && old[jj] != 0) begin
          m_lock[d] = 1;
          m_g[d]    = jj;
          m_ptr[d]  = jj;
          break;
        end
      end
    end
  endtask

  // Inputs are set at a falling edge; outputs settle and are checked before the rising edge.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      model_check(d);
      model_update(d);
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      v_in[d] = '0; t_in[d] = '0; r_in[d] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g_tab [16] = '{0,1,1,1,0,2,2,2,0,1,1,1,0,2,2,2};
  int s_g   [10] = '{0,1,1,1,1,1,1,1,0,2};
  int s_v   [10] = '{0,1,1,0,0,1,0,1,0,1};

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values, then first arbitration picks VC0.
    #1;
    chk("rst_grant", int'(if8.o_grant), 0);
    chk("rst_ready", int'(if8.o_ready), 0);
    chk("rst_valid", int'(if8.o_valid), 0);
    chk("rst_err",   int'(if8.o_credit_error), 0);
    @(negedge clk);
    rst_n = 1'b1;
    v_in[0] = 2'b11;
    step();
    #1;
    chk("first_grant", int'(if8.o_grant), 1);

    // Fairness: alternating 3-flit packets with one idle cycle between them.
    @(negedge clk);
    do_reset();
    for (int s = 0; s < 16; s++) begin
      v_in[0] = 2'b11;
      t_in[0][0] = (sent[0][0] % 3 == 2);
      t_in[0][1] = (sent[0][1] % 3 == 2);
      #1;
      chk($sformatf("fair_grant_s%0d", s), int'(if8.o_grant), g_tab[s]);
      step();
    end

    // Packet lock under credit starvation on the 2-credit instance.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      v_in[1] = 2'b11;
      t_in[1] = {1'b0, sent[1][0] == 3};
      r_in[1] = {1'b0, (s == 4 || s == 6)};
      #1;
      chk($sformatf("starve_grant_s%0d", s), int'(if2.o_grant), s_g[s]);
      chk($sformatf("starve_valid_s%0d", s), int'(if2.o_valid), s_v[s]);
      step();
    end

    // Transfer and return on the same VC in one cycle.
    do_reset();
    v_in[0] = 2'b01;
    repeat (4) step();
    #1;
    chk("same_pre", int'(cr_w[0][0]), 5);
    r_in[0] = 2'b01;
    step();
    r_in[0] = 2'b00;
    #1;
    chk("same_post", int'(cr_w[0][0]), 5);
    t_in[0] = 2'b01;
    step();
    clear_inputs();
    step();

    // Overflow on a full counter sets a sticky error.
    do_reset();
    r_in[0] = 2'b10;
    #1;
    chk("ovf_pre", int'(if8.o_credit_error), 0);
    step();
    r_in[0] = 2'b00;
    #1;
    chk("ovf_set", int'(if8.o_credit_error), 1);
    chk("ovf_cr", int'(cr_w[0][1]), 8);
    repeat (3) step();
    #1;
    chk("ovf_sticky", int'(if8.o_credit_error), 1);

    // Reset asserted during flit 2 of a 4-flit packet.
    do_reset();
    v_in[0] = 2'b01;
    step();
    step();
    #1;
    chk("mid_valid_pre", int'(if8.o_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_grant", int'(if8.o_grant), 0);
    chk("mid_ready", int'(if8.o_ready), 0);
    chk("mid_valid", int'(if8.o_valid), 0);
    chk("mid_cr0",   int'(cr_w[0][0]), 8);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v_in[0] = 2'b11;
    step();
    #1;
    chk("mid_restart", int'(if8.o_grant), 1);

    // Randomized traffic on both instances.
    @(negedge clk);
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        v_in[d] = 2'($urandom_range(0, 3));
        t_in[d][0] = ($urandom_range(0, 2) == 0);
        t_in[d][1] = ($urandom_range(0, 2) == 0);
        r_in[d][0] = (m_cr[d][0] < MAXC[d]) && ($urandom_range(0, 1) == 1);
        r_in[d][1] = (m_cr[d][1] < MAXC[d]) && ($urandom_range(0, 1) == 1);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
